// File: rtl/key_mode_ctrl_if.sv
// Button-to-mode-select bundle: raw key pins in, one-hot mode, index and change strobe out.
interface key_mode_ctrl_if #(
  parameter int NUM_MODES = 3
);
  localparam int IW = $clog2(NUM_MODES);

  logic                 key_next;
  logic                 key_prev;
  logic [NUM_MODES-1:0] change_en;
  logic [IW-1:0]        mode_idx;
  logic                 mode_chg;

  modport master (output key_next, key_prev, input change_en, mode_idx, mode_chg);
  modport slave  (input key_next, key_prev, output change_en, mode_idx, mode_chg);
endinterface

// File: rtl/key_mode_ctrl.sv
// Push-button mode selector: debounces next/prev keys, steps a one-hot mode with
// wrap-around, auto-repeats held keys and returns to RESET_MODE on a two-key chord.
module key_mode_ctrl #(
  parameter int NUM_MODES      = 3,
  parameter int RESET_MODE     = 2,
  parameter int DEBOUNCE_CNT   = 500000,
  parameter int LONG_CNT       = 25000000,
  parameter int REPEAT_CNT     = 5000000,
  parameter bit REPEAT_EN      = 1'b1,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  key_mode_ctrl_if.slave bus
);
  localparam int IW = $clog2(NUM_MODES);
  localparam int HW = $clog2(LONG_CNT + 1);
  localparam logic [HW-1:0]        DEB_H    = HW'(DEBOUNCE_CNT);
  localparam logic [HW-1:0]        LONG_H   = HW'(LONG_CNT);
  // Reload so that successive repeats land exactly REPEAT_CNT cycles apart.
  localparam logic [HW-1:0]        RELOAD_H = HW'(LONG_CNT - REPEAT_CNT + 1);
  localparam logic [IW-1:0]        RST_IDX  = IW'(RESET_MODE);
  localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_MODES - 1);
  localparam logic [NUM_MODES-1:0] RST_EN   = NUM_MODES'(1) << RESET_MODE;
  localparam logic [1:0]           PIN_IDLE = {2{KEY_ACTIVE_LOW}};

  typedef enum logic {ST_FREE, ST_LOCKED} lock_e;

  // Bit 0 is the next key, bit 1 the prev key.
  logic [1:0] w_pin, r_sync0, r_sync1, w_act, w_step, w_dn;

  assign w_pin = {bus.key_prev, bus.key_next};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync0 <= PIN_IDLE;
      r_sync1 <= PIN_IDLE;
    end else begin
      r_sync0 <= w_pin;
      r_sync1 <= r_sync0;
    end
  end

  assign w_act = r_sync1 ^ PIN_IDLE;

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [HW-1:0] r_hold;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                            r_hold <= '0;
      else if (!w_act[k])                        r_hold <= '0;
      else if (REPEAT_EN && (r_hold == LONG_H))  r_hold <= RELOAD_H;
      else if (r_hold < LONG_H)                  r_hold <= r_hold + 1'b1;
    end

    assign w_step[k] = (r_hold == DEB_H) || (REPEAT_EN && (r_hold == LONG_H));
    assign w_dn[k]   = (r_hold >= DEB_H);
  end

  lock_e r_state, w_state_next;
  logic  w_chord, w_release, w_entry, w_hold_off;

  assign w_chord   = &w_dn;
  assign w_release = ~|w_act;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_FREE;
    else            r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_entry      = 1'b0;
    w_hold_off   = 1'b0;
    case (r_state)
      ST_FREE: begin
        if (w_chord) begin
          w_entry = 1'b1;
          if (!w_release) w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        w_hold_off = 1'b1;
        if (w_release) w_state_next = ST_FREE;
      end
    endcase
  end

  logic [IW-1:0]        r_idx, w_idx_next;
  logic [NUM_MODES-1:0] r_en, w_en_next;
  logic                 r_chg;

  always_comb begin
    w_idx_next = r_idx;
    if (w_entry)                       w_idx_next = RST_IDX;
    else if (w_hold_off || (&w_step))  w_idx_next = r_idx;
    else if (w_step[0])                w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    else if (w_step[1])                w_idx_next = (r_idx == '0) ? LAST_IDX : r_idx - 1'b1;
  end

  assign w_en_next = NUM_MODES'(1) << w_idx_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idx <= RST_IDX;
      r_en  <= RST_EN;
      r_chg <= 1'b0;
    end else begin
      r_idx <= w_idx_next;
      r_en  <= w_en_next;
      r_chg <= (w_idx_next != r_idx);
    end
  end

  assign bus.change_en = r_en;
  assign bus.mode_idx  = r_idx;
  assign bus.mode_chg  = r_chg;
endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl: one DUT with auto-repeat, one without, both
// driven by the same pins and compared against a run-length reference model.
module tb_key_mode_ctrl;
  localparam int NM = 3, RM = 2, DEB = 4, LONG = 20, REP = 5;

  logic clk = 1'b0, rst_n = 1'b0, pin_next = 1'b1, pin_prev = 1'b1;
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  key_mode_ctrl_if #(.NUM_MODES(NM)) if_r ();
  key_mode_ctrl_if #(.NUM_MODES(NM)) if_n ();
  assign if_r.key_next = pin_next;
  assign if_r.key_prev = pin_prev;
  assign if_n.key_next = pin_next;
  assign if_n.key_prev = pin_prev;

  key_mode_ctrl #(.NUM_MODES(NM), .RESET_MODE(RM), .DEBOUNCE_CNT(DEB), .LONG_CNT(LONG),
    .REPEAT_CNT(REP), .REPEAT_EN(1'b1), .KEY_ACTIVE_LOW(1'b1))
    dut_r (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if_r));

  key_mode_ctrl #(.NUM_MODES(NM), .RESET_MODE(RM), .DEBOUNCE_CNT(DEB), .LONG_CNT(LONG),
    .REPEAT_CNT(REP), .REPEAT_EN(1'b0), .KEY_ACTIVE_LOW(1'b1))
    dut_n (.sys_clk(clk), .sys_rst_n(rst_n), .bus(if_n));

  // Observed and expected {change_en, mode_idx, mode_chg}; index 0 = repeat DUT, 1 = no-repeat DUT.
  logic [5:0] obs [2];
  logic [5:0] expv[2];
  assign obs[0] = {if_r.change_en, if_r.mode_idx, if_r.mode_chg};
  assign obs[1] = {if_n.change_en, if_n.mode_idx, if_n.mode_chg};

  // Reference model: per key, run_n counts consecutive synchronised-active cycles.
  int run_n[2]    = '{0, 0};
  bit a0[2]       = '{1'b0, 1'b0};
  bit a1[2]       = '{1'b0, 1'b0};
  int m_idx[2]    = '{RM, RM};
  bit m_chg[2]    = '{1'b0, 1'b0};
  bit m_locked[2] = '{1'b0, 1'b0};

  initial forever begin
    bit chord, both_idle;
    bit fire[2];
    int nxt;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        run_n[i] = 0; a0[i] = 1'b0; a1[i] = 1'b0;
        m_idx[i] = RM; m_chg[i] = 1'b0; m_locked[i] = 1'b0;
      end
    end else begin
      chord     = (run_n[0] >= DEB) && (run_n[1] >= DEB);
      both_idle = !a1[0] && !a1[1];
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 2; k++)
          fire[k] = (run_n[k] == DEB) ||
                    (m == 0 && run_n[k] >= LONG && ((run_n[k] - LONG) % REP) == 0);
        nxt = m_idx[m];
        if (chord && !m_locked[m]) nxt = RM;
        else if (!m_locked[m] && !(fire[0] && fire[1])) begin
          if (fire[0])      nxt = (m_idx[m] + 1) % NM;
          else if (fire[1]) nxt = (m_idx[m] + NM - 1) % NM;
        end
        m_chg[m]    = (nxt != m_idx[m]);
        m_idx[m]    = nxt;
        m_locked[m] = (m_locked[m] || chord) && !both_idle;
      end
      for (int k = 0; k < 2; k++) begin
        run_n[k] = a1[k] ? run_n[k] + 1 : 0;
        a1[k]    = a0[k];
      end
      a0[0] = !pin_next;
      a0[1] = !pin_prev;
    end
  end

  always_comb
    for (int m = 0; m < 2; m++)
      expv[m] = {3'(1 << m_idx[m]), 2'(m_idx[m]), m_chg[m]};

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs[m] !== 6'b100_10_0) begin
        bad++; $display("FAIL reset_values[%0d]: got %b want %b", m, obs[m], 6'b100_10_0);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv[m]) begin
          bad++; $display("FAIL reset_idle[%0d] edge %0d: got %b want %b", m, e, obs[m], expv[m]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [63:0] pm;
    pm = '0;
    pin_next = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv[m]) begin
          bad++; $display("FAIL glitch[%0d] edge %0d: got %b want %b", m, e, obs[m], expv[m]);
        end
        if (obs[m][0]) pm[e] = 1'b1;
      end
      if (e == 3) pin_next = 1'b1;
    end
    total++;
    if (pm !== 64'd0 || if_r.mode_idx !== 2'd2 || if_n.mode_idx !== 2'd2) begin
      bad++; $display("FAIL glitch_no_step: pulses %h idx %0d/%0d want none and 2", pm, if_r.mode_idx, if_n.mode_idx);
    end
  endtask

  task automatic test_single_press();
    logic [63:0] pm_r, pm_n, want;
    pm_r = '0; pm_n = '0; want = '0; want[7] = 1'b1;
    pin_next = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv[m]) begin
          bad++; $display("FAIL single[%0d] edge %0d: got %b want %b", m, e, obs[m], expv[m]);
        end
      end
      if (obs[0][0]) pm_r[e] = 1'b1;
      if (obs[1][0]) pm_n[e] = 1'b1;
      if (e == 10) pin_next = 1'b1;
    end
    total++;
    if (pm_r !== want || pm_n !== want) begin
      bad++; $display("FAIL single_pulse_edges: got %h/%h want %h", pm_r, pm_n, want);
    end
    total++;
    if (if_r.change_en !== 3'b001 || if_n.change_en !== 3'b001) begin
      bad++; $display("FAIL single_change_en: got %b/%b want 001", if_r.change_en, if_n.change_en);
    end
  endtask

  task automatic test_wrap();
    for (int p = 0; p < 2; p++) begin
      if (p == 0) pin_prev = 1'b0;
      else        pin_next = 1'b0;
      for (int e = 1; e <= 14; e++) begin
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
          total++;
          if (obs[m] !== expv[m]) begin
            bad++; $display("FAIL wrap%0d[%0d] edge %0d: got %b want %b", p, m, e, obs[m], expv[m]);
          end
        end
        if (e == 8) begin pin_prev = 1'b1; pin_next = 1'b1; end
      end
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m][2:1] !== ((p == 0) ? 2'd2 : 2'd0)) begin
          bad++; $display("FAIL wrap_idx%0d[%0d]: got %0d want %0d", p, m, obs[m][2:1], (p == 0) ? 2 : 0);
        end
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [63:0] pm_r, pm_n, want_r, want_n;
    int rep_edge[5] = '{7, 23, 28, 33, 38};
    int rep_val[5]  = '{0, 1, 2, 0, 1};
    pm_r = '0; pm_n = '0; want_r = '0; want_n = '0;
    for (int j = 0; j < 5; j++) want_r[rep_edge[j]] = 1'b1;
    want_n[7] = 1'b1;
    pin_prev = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv[m]) begin
          bad++; $display("FAIL repeat_setup[%0d] edge %0d: got %b want %b", m, e, obs[m], expv[m]);
        end
      end
      if (e == 8) pin_prev = 1'b1;
    end
    pin_next = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv[m]) begin
          bad++; $display("FAIL repeat[%0d] edge %0d: got %b want %b", m, e, obs[m], expv[m]);
        end
      end
      if (e <= 40 && obs[0][0]) pm_r[e] = 1'b1;
      if (e <= 40 && obs[1][0]) pm_n[e] = 1'b1;
      for (int j = 0; j < 5; j++)
        if (e == rep_edge[j]) begin
          total++;
          if (if_r.mode_idx !== 2'(rep_val[j])) begin
            bad++; $display("FAIL repeat_idx edge %0d: got %0d want %0d", e, if_r.mode_idx, rep_val[j]);
          end
        end
      if (e == 40) begin
        pin_next = 1'b1;
        total++;
        if (if_n.mode_idx !== 2'd0) begin
          bad++; $display("FAIL norepeat_idx: got %0d want 0", if_n.mode_idx);
        end
      end
    end
    total++;
    if (pm_r !== want_r) begin
      bad++; $display("FAIL repeat_pulse_edges: got %h want %h", pm_r, want_r);
    end
    total++;
    if (pm_n !== want_n) begin
      bad++; $display("FAIL norepeat_pulse_edges: got %h want %h", pm_n, want_n);
    end
  endtask

  task automatic test_chord();
    logic [63:0] pm_r, pm_n, want;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      pm_r = '0; pm_n = '0; want = '0; want[7] = 1'b1;
      if (ph == 1) want[9] = 1'b1;
      pin_next = 1'b0;
      for (int e = 1; e <= ((ph == 1) ? 40 : 14); e++) begin
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
          total++;
          if (obs[m] !== expv[m]) begin
            bad++; $display("FAIL chord%0d[%0d] edge %0d: got %b want %b", ph, m, e, obs[m], expv[m]);
          end
          if (obs[m][0] && m == 0) pm_r[e] = 1'b1;
          if (obs[m][0] && m == 1) pm_n[e] = 1'b1;
          if (ph == 1 && (e == 7 || e == 9)) begin
            total++;
            if (obs[m][2:1] !== ((e == 7) ? 2'd1 : 2'd2)) begin
              bad++; $display("FAIL chord_idx[%0d] edge %0d: got %0d want %0d", m, e, obs[m][2:1], (e == 7) ? 1 : 2);
            end
          end
        end
        if (ph == 1 && e == 2) pin_prev = 1'b0;
        if ((ph == 1) ? (e == 32) : (e == 8)) begin pin_next = 1'b1; pin_prev = 1'b1; end
      end
      total++;
      if (pm_r !== want || pm_n !== want) begin
        bad++; $display("FAIL chord_pulses%0d: got %h/%h want %h", ph, pm_r, pm_n, want);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [63:0] pm;
    pm = '0;
    pin_next = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv[m]) begin
          bad++; $display("FAIL midhold[%0d] edge %0d: got %b want %b", m, e, obs[m], expv[m]);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs[m] !== 6'b100_10_0) begin
        bad++; $display("FAIL midhold_reset[%0d]: got %b want %b", m, obs[m], 6'b100_10_0);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv[m]) begin
          bad++; $display("FAIL after_reset[%0d] edge %0d: got %b want %b", m, e, obs[m], expv[m]);
        end
        if (obs[m][0]) pm[e] = 1'b1;
      end
      if (e == 10) pin_next = 1'b1;
    end
    total++;
    if (pm !== 64'h80 || if_r.mode_idx !== 2'd0 || if_n.mode_idx !== 2'd0) begin
      bad++; $display("FAIL after_reset_step: pulses %h idx %0d/%0d want 80 and 0", pm, if_r.mode_idx, if_n.mode_idx);
    end
  endtask

  task automatic test_random();
    int dur_next = 0, dur_prev = 0;
    for (int c = 0; c < 420; c++) begin
      if (c >= 400) begin pin_next = 1'b1; pin_prev = 1'b1; end
      else begin
        if (dur_next == 0) begin pin_next = ~pin_next; dur_next = int'($urandom_range(1, 28)); end
        else dur_next--;
        if (dur_prev == 0) begin pin_prev = ~pin_prev; dur_prev = int'($urandom_range(1, 28)); end
        else dur_prev--;
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv[m]) begin
          bad++; $display("FAIL random[%0d] cycle %0d: got %b want %b", m, c, obs[m], expv[m]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_press();
    test_wrap();
    test_auto_repeat();
    test_chord();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
